multdiv_unit: RTL

// Multi-cycle signed multiply/divide unit in the execute stage, directly downstream of the D/X decoder.
// The decoder's isMult/isDiv strobes start an operation on its forwarded outA/outB operands.

---
 rtl/multdiv_if.sv | 27 ++
 rtl/multdiv_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multdiv_if.sv
// Start/result bundle between the D/X decoder, the multiply/divide unit and the X/M latch.
// A start strobe is accepted only while busy is low; data_resultRDY is a one-cycle strobe with no back-pressure.
interface multdiv_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [TAG_W-1:0] tag_in;
  logic             busy;
  logic             data_resultRDY;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, tag_in,
    input  busy, data_resultRDY, data_result, data_exception, tag_out
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, tag_in,
    output busy, data_resultRDY, data_result, data_exception, tag_out
  );
endinterface

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring) unit for the execute stage.
// One iteration per cycle; result, exception flag and tag are presented in the DONE cycle.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic       clock,
  input  logic       reset,
  multdiv_if.slave   bus,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;

  logic [WIDTH:0]     acc_ext, mc_ext, booth_sum;
  logic [2*WIDTH:0]   booth_next;
  logic [WIDTH:0]     prod_hi;
  logic               prod_fits;
  logic [WIDTH:0]     shifted, diff;
  logic               quo_bit;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               min_a;

  // Accumulator is extended by one bit so subtracting the most negative multiplicand cannot wrap.
  always_comb begin
    acc_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    mc_ext  = {mcand_q[WIDTH-1], mcand_q};
    unique case (prod_q[1:0])
      2'b01:   booth_sum = acc_ext + mc_ext;
      2'b10:   booth_sum = acc_ext - mc_ext;
      default: booth_sum = acc_ext;
    endcase
    booth_next = {booth_sum, prod_q[WIDTH:1]};
    prod_hi    = booth_next[2*WIDTH:WIDTH];
    prod_fits  = (&prod_hi) | ~(|prod_hi);
  end

  always_comb begin
    shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvsr_q};
    quo_bit  = ~diff[WIDTH];
    rem_next = quo_bit ? diff : shifted;
    quo_next = {quo_q[WIDTH-2:0], quo_bit};
    abs_a    = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    abs_b    = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    min_a    = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_d     = neg_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    tag_d     = tag_q;
    res_d     = res_q;
    exc_d     = exc_q;
    tag_out_d = tag_out_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.ctrl_MULT) begin
          state_d = MULT;
          cnt_d   = '0;
          mcand_d = bus.data_operandA;
          prod_d  = {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
          tag_d   = bus.tag_in;
        end else if (bus.ctrl_DIV) begin
          state_d = DIV;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = abs_a;
          dvsr_d  = abs_b;
          neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          dz_d    = (bus.data_operandB == '0);
          ovf_d   = min_a && (&bus.data_operandB);
          tag_d   = bus.tag_in;
        end
      end
      MULT: begin
        prod_d = booth_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = DONE;
          res_d     = booth_next[WIDTH:1];
          exc_d     = ~prod_fits;
          tag_out_d = tag_q;
        end
      end
      DIV: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (dz_q) begin
          state_d   = DONE;
          res_d     = '0;
          exc_d     = 1'b1;
          tag_out_d = tag_q;
        end else if (cnt_q == LAST) begin
          state_d   = DONE;
          res_d     = neg_q ? -quo_next : quo_next;
          exc_d     = ovf_q;
          tag_out_d = tag_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_q     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      tag_q     <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_q     <= neg_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      tag_q     <= tag_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      tag_out_q <= tag_out_d;
    end
  end

  assign bus.busy           = (state_q == MULT) || (state_q == DIV);
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.tag_out        = tag_out_q;
  assign dbg_state_o        = state_q;
endmodule
